// File: rtl/tdm_demux.sv
// tdm_demux -- receive end of the TDM serial link.
//
// Frames a bit-serial stream (SYNC_PAT followed by NUM_CH slots of CH_W bits,
// channel 0 first, MSB first), tracks frame alignment and distributes each
// frame to parallel channel words. Only cycles with bit_en_i=1 advance state.
//
// Optional feature: define PARITY_EN to append one even-parity bit to every
// slot (data MSB first, parity last) and report per-channel parity errors.
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous, active-high reset
//   bit_i          in   serial data, sampled only when bit_en_i=1
//   bit_en_i       in   bit strobe, one serial bit per high cycle
//   ch_data_o      out  channel k at [k*CH_W +: CH_W]; held between frames
//   frame_valid_o  out  1-cycle pulse: ch_data_o updated with a new frame
//   locked_o       out  frame alignment established
//   sync_err_o     out  1-cycle pulse: expected sync word mismatched
//   par_err_o      out  per-channel parity error, valid with frame_valid_o
module tdm_demux #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_W     = 8,
  parameter int unsigned SYNC_W   = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     bit_i,
  input  logic                     bit_en_i,
  output logic [NUM_CH*CH_W-1:0]   ch_data_o,
  output logic                     frame_valid_o,
  output logic                     locked_o,
  output logic                     sync_err_o,
  output logic [NUM_CH-1:0]        par_err_o
);

`ifdef PARITY_EN
  localparam int unsigned SLOT_W = CH_W + 1;
`else
  localparam int unsigned SLOT_W = CH_W;
`endif
  localparam int unsigned PAY_W   = SLOT_W * NUM_CH;
  localparam int unsigned CNT_MAX = ((PAY_W > SYNC_W) ? PAY_W : SYNC_W) - 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FILL_W  = $clog2(SYNC_W + 1);
  localparam int unsigned GOOD_W  = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  PAY_LAST  = CNT_W'(PAY_W - 1);
  localparam logic [CNT_W-1:0]  SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    PAYLOAD  = 2'd1,
    SYNC_CHK = 2'd2
  } state_t;

  state_t state, state_nx;

  // The shift registers keep only the older W-1 bits; the word completed by
  // the current strobe is {history, bit_i}, so sync/payload decisions are made
  // on the strobe carrying the last bit rather than one strobe later.
  logic [SYNC_W-2:0] sync_hist;
  logic [PAY_W-2:0]  pay_hist;
  logic [SYNC_W-1:0] sync_word;
  logic [PAY_W-1:0]  pay_word;
  logic              sync_ok;

  logic [FILL_W-1:0] fill, fill_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [GOOD_W-1:0] good, good_nx;
  logic              load_frame;
  logic              sync_bad;

  logic [NUM_CH*CH_W-1:0] frame_data;
  logic [SLOT_W-1:0]      slot;
`ifdef PARITY_EN
  logic [NUM_CH-1:0]      frame_par;
`endif

  assign sync_word = {sync_hist, bit_i};
  assign pay_word  = {pay_hist, bit_i};
  assign sync_ok   = (sync_word == SYNC_PAT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= HUNT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    fill_nx    = fill;
    cnt_nx     = cnt;
    good_nx    = good;
    load_frame = 1'b0;
    sync_bad   = 1'b0;
    if (bit_en_i) begin
      case (state)
        HUNT: begin
          if (fill != FILL_FULL) fill_nx = fill + FILL_W'(1);
          if ((fill_nx == FILL_FULL) && sync_ok) begin
            state_nx = PAYLOAD;
            cnt_nx   = '0;
            fill_nx  = '0;
            good_nx  = GOOD_W'(1);
          end
        end
        PAYLOAD: begin
          if (cnt == PAY_LAST) begin
            load_frame = locked_o;
            cnt_nx     = '0;
            state_nx   = SYNC_CHK;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        SYNC_CHK: begin
          if (cnt == SYNC_LAST) begin
            cnt_nx = '0;
            if (sync_ok) begin
              state_nx = PAYLOAD;
              if (good != GOOD_MAX) good_nx = good + GOOD_W'(1);
            end else begin
              // Hunt restarts with an empty window after a lost frame.
              state_nx = HUNT;
              good_nx  = '0;
              sync_bad = 1'b1;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // Slot k sits at the top of the payload word for k=0 (sent first).
  always_comb begin
    frame_data = '0;
    slot       = '0;
`ifdef PARITY_EN
    frame_par  = '0;
`endif
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      slot = pay_word[(NUM_CH-1-k)*SLOT_W +: SLOT_W];
      frame_data[k*CH_W +: CH_W] = slot[SLOT_W-1 -: CH_W];
`ifdef PARITY_EN
      frame_par[k] = ^slot;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill          <= '0;
      cnt           <= '0;
      good          <= '0;
      sync_hist     <= '0;
      pay_hist      <= '0;
      locked_o      <= 1'b0;
      frame_valid_o <= 1'b0;
      sync_err_o    <= 1'b0;
      ch_data_o     <= '0;
    end else begin
      fill          <= fill_nx;
      cnt           <= cnt_nx;
      good          <= good_nx;
      locked_o      <= (good_nx >= GOOD_MAX);
      frame_valid_o <= load_frame;
      sync_err_o    <= sync_bad;
      if (bit_en_i) begin
        if (state == PAYLOAD) pay_hist  <= pay_word[PAY_W-2:0];
        else                  sync_hist <= sync_word[SYNC_W-2:0];
      end
      if (load_frame) ch_data_o <= frame_data;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           par_err_o <= '0;
    else if (load_frame) par_err_o <= frame_par;
  end
`else
  assign par_err_o = '0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: default instance (4 x 8-bit channels, LOCK_CNT=2) plus
// a small instance (2 x 4-bit channels, LOCK_CNT=1). Expected frames are queued
// when their last payload bit is driven and compared when frame_valid_o fires.
module tb_tdm_demux;

`ifdef PARITY_EN
  localparam int unsigned SLOT_W  = 9;
  localparam int unsigned SLOT6_W = 5;
`else
  localparam int unsigned SLOT_W  = 8;
  localparam int unsigned SLOT6_W = 4;
`endif
  localparam logic [31:0] DATA_A = 32'h4433_2211;
  localparam logic [31:0] DATA_B = 32'h8877_6655;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  par;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i, bit_i, bit_en_i;
  logic [31:0] ch_data_o;
  logic        frame_valid_o, locked_o, sync_err_o;
  logic [3:0]  par_err_o;

  logic        bit6, en6;
  logic [7:0]  ch6;
  logic        fv6, locked6, serr6;
  logic [1:0]  par6;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          serr_cnt = 0;
  logic [31:0] prev_ch = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdm_demux dut (
    .clk_i(clk), .rst_i(rst_i), .bit_i(bit_i), .bit_en_i(bit_en_i),
    .ch_data_o(ch_data_o), .frame_valid_o(frame_valid_o), .locked_o(locked_o),
    .sync_err_o(sync_err_o), .par_err_o(par_err_o)
  );

  tdm_demux #(.NUM_CH(2), .CH_W(4), .LOCK_CNT(1)) dut6 (
    .clk_i(clk), .rst_i(rst_i), .bit_i(bit6), .bit_en_i(en6),
    .ch_data_o(ch6), .frame_valid_o(fv6), .locked_o(locked6),
    .sync_err_o(serr6), .par_err_o(par6)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pop, hold check, sync error pulse count.
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      prev_ch = '0;
    end else begin
      if (frame_valid_o) begin
        if (sb.size() == 0) begin
          check("fv_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("ch_data", ch_data_o, e.data);
          check("par_err", par_err_o, e.par);
          check("latency", cyc, e.cyc);
        end
      end else begin
        check("hold", ch_data_o, prev_ch);
      end
      if (sync_err_o) serr_cnt++;
      prev_ch = ch_data_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] build_pay(input logic [31:0] d, input int flip);
    logic [63:0] p;
    p = '0;
    for (int k = 0; k < 4; k++) begin
`ifdef PARITY_EN
      p = (p << 9) | 64'({d[k*8 +: 8], (^d[k*8 +: 8]) ^ (flip == k)});
`else
      p = (p << 8) | 64'(d[k*8 +: 8]);
`endif
    end
    return p;
  endfunction

  // Called at posedge+1; bit is captured by the next posedge.
  task automatic send_bits(input logic [63:0] v, input int unsigned n,
                           input int unsigned gap, input bit push, input exp_t e);
    for (int unsigned i = 0; i < n; i++) begin
      bit_i    = v[n-1-i];
      bit_en_i = 1'b1;
      @(posedge clk); #1;
      bit_en_i = 1'b0;
      if (push && (i == n - 1)) begin
        e.cyc = cyc;
        sb.push_back(e);
      end
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_frame(input logic [7:0] sync, input logic [31:0] d,
                            input int unsigned gap, input bit out, input int flip);
    exp_t e;
    e.data = d;
    e.cyc  = 0;
`ifdef PARITY_EN
    e.par  = (flip >= 0) ? 4'(1 << flip) : 4'b0;
`else
    e.par  = 4'b0;
`endif
    send_bits(64'(sync), 8, gap, 1'b0, e);
    send_bits(build_pay(d, flip), 4 * SLOT_W, gap, out, e);
  endtask

  task automatic settle();
    repeat (2) begin @(posedge clk); #1; end
    check("sb_drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bit_en_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_ch", ch_data_o, 0);
    check("rst_fv", frame_valid_o, 0);
    check("rst_lock", locked_o, 0);
    check("rst_serr", sync_err_o, 0);
    check("rst_par", par_err_o, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int   base;
    exp_t dummy;
    logic [63:0] pay;
    logic [63:0] v6;
    dummy.data = '0; dummy.par = '0; dummy.cyc = 0;
    rst_i = 1'b1; bit_i = 1'b0; bit_en_i = 1'b0; bit6 = 1'b0; en6 = 1'b0;
    @(posedge clk); #1;

    // 1: three frames, first one discarded while lock builds
    do_reset();
    send_frame(8'hA5, DATA_A, 0, 1'b0, -1);
    check("t1_lock_f1", locked_o, 0);
    send_frame(8'hA5, DATA_A, 0, 1'b1, -1);
    check("t1_lock_f2", locked_o, 1);
    send_frame(8'hA5, DATA_A, 0, 1'b1, -1);
    settle();
    check("t1_data", ch_data_o, DATA_A);
    check("t1_par", par_err_o, 0);

    // 2: corrupted sync drops lock, two good syncs relock
    base = serr_cnt;
    send_frame(8'hA4, DATA_A, 0, 1'b0, -1);
    check("t2_serr_once", serr_cnt - base, 1);
    check("t2_unlock", locked_o, 0);
    send_frame(8'hA5, DATA_B, 0, 1'b0, -1);
    check("t2_lock_hunt", locked_o, 0);
    send_frame(8'hA5, DATA_B, 0, 1'b1, -1);
    settle();
    check("t2_relock", locked_o, 1);
    check("t2_data", ch_data_o, DATA_B);

    // 3: leading garbage, strobe every third cycle
    do_reset();
    base = serr_cnt;
    send_bits(64'h5A, 8, 2, 1'b0, dummy);
    send_bits(64'hFF, 8, 2, 1'b0, dummy);
    send_frame(8'hA5, DATA_A, 2, 1'b0, -1);
    send_frame(8'hA5, DATA_A, 2, 1'b1, -1);
    send_frame(8'hA5, DATA_A, 2, 1'b1, -1);
    settle();
    check("t3_data", ch_data_o, DATA_A);
    check("t3_lock", locked_o, 1);
    check("t3_no_serr", serr_cnt - base, 0);

    // 4: reset in the middle of a locked frame's payload
    do_reset();
    send_frame(8'hA5, DATA_B, 0, 1'b0, -1);
    send_frame(8'hA5, DATA_B, 0, 1'b1, -1);
    settle();
    check("t4_pre_lock", locked_o, 1);
    pay = build_pay(DATA_A, -1);
    send_bits(64'hA5, 8, 0, 1'b0, dummy);
    send_bits(pay >> (2 * SLOT_W), 2 * SLOT_W, 0, 1'b0, dummy);
    rst_i = 1'b1;
    #1;
    check("t4_rst_ch", ch_data_o, 0);
    check("t4_rst_lock", locked_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    send_bits(pay, 2 * SLOT_W, 0, 1'b0, dummy);
    send_frame(8'hA5, DATA_A, 0, 1'b0, -1);
    check("t4_no_early_lock", locked_o, 0);
    send_frame(8'hA5, DATA_A, 0, 1'b1, -1);
    settle();
    check("t4_relock", locked_o, 1);
    check("t4_data", ch_data_o, DATA_A);

    // 5: parity error on channel 2 does not drop lock
`ifdef PARITY_EN
    send_frame(8'hA5, DATA_B, 0, 1'b1, 2);
`else
    send_frame(8'hA5, DATA_B, 0, 1'b1, -1);
`endif
    settle();
    check("t5_lock", locked_o, 1);
`ifndef PARITY_EN
    check("t5_par_zero", par_err_o, 0);
`endif

    // 6: small instance, LOCK_CNT=1 outputs the first frame
`ifdef PARITY_EN
    v6 = {45'b0, 8'hA5, 4'h3, 1'b0, 4'hC, 1'b0};
`else
    v6 = {48'b0, 8'hA5, 4'h3, 4'hC};
`endif
    for (int unsigned i = 0; i < 8 + 2 * SLOT6_W; i++) begin
      bit6 = v6[8 + 2*SLOT6_W - 1 - i];
      en6  = 1'b1;
      @(posedge clk); #1;
      en6  = 1'b0;
    end
    @(negedge clk);
    check("t6_fv", fv6, 1);
    check("t6_data", ch6, 8'hC3);
    check("t6_lock", locked6, 1);
    check("t6_par", par6, 0);
    @(negedge clk);
    check("t6_fv_pulse", fv6, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
